// File: rtl/popcnt_pkg.sv
// ---------------------------------------------------------------------------
// popcnt_pkg
//   Shared definitions for the vector-popcount datapath.
//   - popcnt_w(): width needed to hold a popcount of a vec_width-bit vector
//     (0..vec_width inclusive). The popcount stage uses the same function, so
//     producer and consumer always agree on the score width.
//   - argmin_state_t: two-state control of popcount_argmin.
// ---------------------------------------------------------------------------
package popcnt_pkg;

  function automatic int popcnt_w(input int vec_width);
    return $clog2(vec_width + 1);
  endfunction

  typedef enum logic {
    ACCUM = 1'b0,
    OUT   = 1'b1
  } argmin_state_t;

endpackage

// File: rtl/popcount_argmin.sv
// ---------------------------------------------------------------------------
// popcount_argmin
//   Consumes one Hamming-distance score per input handshake and groups
//   NUM_CAND consecutive scores into a frame. For each frame it reports the
//   minimum score, the index of the first candidate holding that minimum and
//   a flag telling whether the minimum is within MATCH_THRESH. The result is
//   held on the outputs until the downstream accepts it.
//
// Ports
//   clk         in   rising-edge clock
//   rst         in   asynchronous, active-high reset
//   popcount    in   incoming score (0..VEC_WIDTH)
//   in_valid    in   popcount is valid
//   this_ready  out  block accepts popcount this cycle
//   best_score  out  minimum score of the frame
//   best_idx    out  candidate index (0..NUM_CAND-1) of the minimum
//   match       out  best_score <= MATCH_THRESH
//   out_valid   out  result valid
//   next_ready  in   downstream accepts the result
// ---------------------------------------------------------------------------
module popcount_argmin
  import popcnt_pkg::*;
#(
  parameter int VEC_WIDTH    = 1100,
  parameter int POPCNT_WIDTH = popcnt_w(VEC_WIDTH),
  parameter int NUM_CAND     = 4,
  parameter int IDX_WIDTH    = (NUM_CAND > 1) ? $clog2(NUM_CAND) : 1,
  parameter int MATCH_THRESH = 400
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [POPCNT_WIDTH-1:0] popcount,
  input  logic                    in_valid,
  output logic                    this_ready,
  output logic [POPCNT_WIDTH-1:0] best_score,
  output logic [IDX_WIDTH-1:0]    best_idx,
  output logic                    match,
  output logic                    out_valid,
  input  logic                    next_ready
);

  // Index of the last candidate of a frame, sized to the counter.
  localparam logic [IDX_WIDTH-1:0]    LAST_CNT = IDX_WIDTH'(NUM_CAND - 1);
  // Threshold at score width; scores never exceed VEC_WIDTH so this fits
  // whenever MATCH_THRESH is a meaningful score.
  localparam logic [POPCNT_WIDTH-1:0] THRESH   = POPCNT_WIDTH'(MATCH_THRESH);
  localparam logic [IDX_WIDTH-1:0]    CNT_ONE  = IDX_WIDTH'(1);

  argmin_state_t          state;
  logic [IDX_WIDTH-1:0]   cand_cnt;

  // Running minimum of the frame in progress (data only, no reset needed:
  // candidate 0 always overwrites it).
  logic [POPCNT_WIDTH-1:0] run_min_p0;
  logic [IDX_WIDTH-1:0]    run_idx_p0;

  logic                    in_hs;
  logic                    out_hs;
  logic                    first_cand;
  logic                    last_cand;
  logic                    take_new;
  logic [POPCNT_WIDTH-1:0] nxt_min;
  logic [IDX_WIDTH-1:0]    nxt_idx;

  // In OUT the block only takes a new score when the held result leaves in
  // the same cycle, so nothing is lost and no frame overlaps the result.
  assign this_ready = (state == ACCUM) ? 1'b1 : next_ready;
  assign in_hs      = in_valid && this_ready;
  assign out_hs     = out_valid && next_ready;

  // cand_cnt is 0 whenever the state is OUT, so an input accepted together
  // with the output handshake naturally becomes candidate 0 of a new frame.
  assign first_cand = (cand_cnt == '0);
  assign last_cand  = (cand_cnt == LAST_CNT);

  // Strict less-than: on a tie the earlier (lower) index is kept.
  assign take_new   = first_cand || (popcount < run_min_p0);
  assign nxt_min    = take_new ? popcount : run_min_p0;
  assign nxt_idx    = take_new ? cand_cnt : run_idx_p0;

  // ---- stage p0: running min/argmin of the open frame ----
  always_ff @(posedge clk) begin
    if (in_hs && !last_cand) begin
      run_min_p0 <= nxt_min;
      run_idx_p0 <= nxt_idx;
    end
  end

  // ---- stage p1: frame control and registered result ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ACCUM;
      cand_cnt   <= '0;
      out_valid  <= 1'b0;
      best_score <= '1;
      best_idx   <= '0;
      match      <= 1'b0;
    end else begin
      if (in_hs && last_cand) begin
        // Frame closes: publish the result. With NUM_CAND==1 this also
        // covers an input accepted in OUT, which closes the next frame and
        // keeps the block in OUT with fresh outputs.
        best_score <= nxt_min;
        best_idx   <= nxt_idx;
        match      <= (nxt_min <= THRESH);
        out_valid  <= 1'b1;
        cand_cnt   <= '0;
        state      <= OUT;
      end else if (in_hs) begin
        // Either accumulating, or the result left together with candidate
        // 0 of the next frame.
        cand_cnt   <= cand_cnt + CNT_ONE;
        out_valid  <= 1'b0;
        state      <= ACCUM;
      end else if (out_hs) begin
        out_valid  <= 1'b0;
        state      <= ACCUM;
      end
    end
  end

endmodule

// File: tb/tb_popcount_argmin.sv
// ---------------------------------------------------------------------------
// tb_popcount_argmin
//   Directed scenarios plus randomized traffic for popcount_argmin at default
//   parameters. A frame-level reference model collects accepted scores and,
//   every NUM_CAND of them, computes the expected min/argmin/match; the
//   monitor compares the DUT's handshake signals and held result against it.
// ---------------------------------------------------------------------------
module tb_popcount_argmin;

  localparam int VW = 1100;
  localparam int PW = 11;
  localparam int NC = 4;
  localparam int IW = 2;
  localparam int TH = 400;

  logic          clk;
  logic          rst;
  logic [PW-1:0] popcount;
  logic          in_valid;
  logic          this_ready;
  logic [PW-1:0] best_score;
  logic [IW-1:0] best_idx;
  logic          match;
  logic          out_valid;
  logic          next_ready;

  popcount_argmin #(
    .VEC_WIDTH   (VW),
    .POPCNT_WIDTH(PW),
    .NUM_CAND    (NC),
    .IDX_WIDTH   (IW),
    .MATCH_THRESH(TH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .popcount  (popcount),
    .in_valid  (in_valid),
    .this_ready(this_ready),
    .best_score(best_score),
    .best_idx  (best_idx),
    .match     (match),
    .out_valid (out_valid),
    .next_ready(next_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int score;
    int idx;
    int match;
  } res_t;

  res_t exp_q[$];
  res_t got_log[$];
  int   acc_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   out_cnt = 0;
  bit   rnd_nr = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  // Frame-level reference: minimum of NUM_CAND accepted scores, first index
  // holding it, and the threshold compare.
  function automatic void model_push(input int s);
    res_t r;
    acc_q.push_back(s);
    if (acc_q.size() == NC) begin
      r.score = acc_q[0];
      r.idx   = 0;
      for (int i = 1; i < NC; i++) begin
        if (acc_q[i] < r.score) begin
          r.score = acc_q[i];
          r.idx   = i;
        end
      end
      r.match = (r.score <= TH) ? 1 : 0;
      exp_q.push_back(r);
      acc_q.delete();
    end
  endfunction

  always @(posedge rst) begin
    acc_q.delete();
    exp_q.delete();
  end

  // Sampled on the falling edge: inputs change just after the rising edge,
  // so these are the values the next rising edge will act on.
  always @(negedge clk) begin : mon
    bit   have;
    bit   tr_exp;
    res_t r;
    if (!rst) begin
      have   = (exp_q.size() != 0);
      tr_exp = have ? next_ready : 1'b1;
      chk("out_valid", out_valid, have);
      chk("this_ready", this_ready, tr_exp);
      if (have) begin
        chk("best_score", best_score, exp_q[0].score);
        chk("best_idx", best_idx, exp_q[0].idx);
        chk("match", match, exp_q[0].match);
      end
      if (have && next_ready) begin
        r = exp_q.pop_front();
        got_log.push_back(r);
        out_cnt++;
      end
      if (in_valid && tr_exp) model_push(int'(popcount));
    end
  end

  always @(posedge clk) begin
    if (rnd_nr) begin
      #1;
      next_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Called just after a rising edge; returns just after the rising edge that
  // accepted the score.
  task automatic send(input int s, input int gap);
    int t;
    bit ok;
    in_valid = 1'b0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    popcount = PW'(s);
    in_valid = 1'b1;
    t  = 0;
    ok = 1'b0;
    do begin
      @(negedge clk);
      ok = this_ready;
      @(posedge clk);
      #1;
      t++;
    end while (!ok && t < 500);
    in_valid = 1'b0;
    if (!ok) chk("send_timeout", 0, 1);
  endtask

  task automatic wait_out(input int target);
    int t;
    t = 0;
    while (out_cnt < target && t < 100) begin
      @(posedge clk);
      t++;
    end
    #1;
    chk("wait_out_timeout", (out_cnt >= target), 1);
  endtask

  task automatic chk_res(input string tag, input int k, input int s, input int i, input int m);
    if (k < got_log.size()) begin
      chk({tag, "_score"}, got_log[k].score, s);
      chk({tag, "_idx"}, got_log[k].idx, i);
      chk({tag, "_match"}, got_log[k].match, m);
    end else begin
      chk({tag, "_missing"}, got_log.size(), k + 1);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, out_cnt %0d", out_cnt);
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int sc;
    int t;
    rst        = 1'b1;
    in_valid   = 1'b0;
    popcount   = '0;
    next_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_this_ready", this_ready, 1);
    chk("rst_best_score", best_score, 11'h7FF);
    chk("rst_best_idx", best_idx, 0);
    chk("rst_match", match, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Test 1: async reset while a result is held
    send(100, 0);
    send(200, 0);
    next_ready = 1'b0;
    send(150, 0);
    send(120, 0);
    chk("t1_held_valid", out_valid, 1);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("t1_async_out_valid", out_valid, 0);
    chk("t1_async_this_ready", this_ready, 1);
    @(posedge clk);
    #1;
    rst        = 1'b0;
    next_ready = 1'b1;
    base       = out_cnt;
    send(40, 0);
    send(30, 0);
    send(20, 0);
    repeat (5) @(posedge clk);
    #1;
    chk("t1_no_early_out", out_cnt, base);
    send(10, 0);
    wait_out(base + 1);
    chk_res("t1", base, 10, 3, 1);

    // Test 2: basic frame with a tie
    base = out_cnt;
    send(500, 0);
    send(300, 0);
    send(700, 0);
    send(300, 0);
    chk("t2_latency", out_valid, 1);
    wait_out(base + 1);
    chk("t2_one_cycle", out_valid, 0);
    chk_res("t2", base, 300, 1, 1);

    // Test 3: all scores at VEC_WIDTH with gaps
    base = out_cnt;
    for (int i = 0; i < NC; i++) send(VW, 2);
    wait_out(base + 1);
    chk_res("t3", base, 1100, 0, 0);

    // Test 4: backpressure with a pending upstream score
    base       = out_cnt;
    next_ready = 1'b0;
    send(9, 0);
    send(8, 0);
    send(7, 0);
    send(6, 0);
    fork
      send(77, 0);
      begin
        repeat (5) @(posedge clk);
        #1;
        chk("t4_held_no_hs", out_cnt, base);
        chk("t4_this_ready_low", this_ready, 0);
        next_ready = 1'b1;
      end
    join
    repeat (2) @(posedge clk);
    #1;
    chk("t4_one_hs", out_cnt - base, 1);
    chk_res("t4", base, 6, 3, 1);
    send(78, 0);
    send(79, 0);
    send(80, 0);
    wait_out(base + 2);
    chk_res("t4_next", base + 1, 77, 0, 1);

    // Test 5: two frames with in_valid held continuously
    base = out_cnt;
    send(10, 0);
    send(20, 0);
    send(30, 0);
    send(40, 0);
    send(50, 0);
    send(5, 0);
    send(60, 0);
    send(70, 0);
    wait_out(base + 2);
    chk_res("t5_a", base, 10, 0, 1);
    chk_res("t5_b", base + 1, 5, 1, 1);

    // Test 6: reset discards a partial frame
    send(3, 0);
    send(2, 0);
    @(posedge clk);
    #3;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst  = 1'b0;
    base = out_cnt;
    send(900, 0);
    send(800, 0);
    send(850, 0);
    send(801, 0);
    wait_out(base + 1);
    repeat (3) @(posedge clk);
    #1;
    chk("t6_single", out_cnt - base, 1);
    chk_res("t6", base, 800, 1, 0);

    // Randomized traffic with random downstream backpressure
    rnd_nr = 1'b1;
    for (int i = 0; i < 200; i++) begin
      case ($urandom_range(0, 2))
        0:       sc = $urandom_range(0, VW);
        1:       sc = $urandom_range(0, 3);
        default: sc = ($urandom_range(0, 1) != 0) ? VW : 0;
      endcase
      send(sc, $urandom_range(0, 2));
    end
    rnd_nr = 1'b0;
    @(posedge clk);
    #2;
    next_ready = 1'b1;
    t = 0;
    while (exp_q.size() != 0 && t < 50) begin
      @(posedge clk);
      t++;
    end
    #1;
    chk("drain_results", exp_q.size(), 0);
    chk("drain_partial", acc_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
